mem_cmd_channel_port: RTL and testbench
=======================================

MEM_CMD_CHANNEL_PORT -- requirements
Module: mem_cmd_channel_port

Interface
REQ-001 Parameter DATA_W, default 8, bus/FSM data width; legal values are 8 and above.
REQ-002 Parameter ADDR_BYTES, default 3, number of address beats following a command; legal range 1..4.
REQ-003 Parameter MOD_ID, default 2'b00, this port's unit ID on the command and ack buses.
REQ-004 Parameter FIFO_DEPTH, default 4, data buffer entries; must be a power of 2, at least 2.
REQ-005 Parameter TIMEOUT_CYC, default 255, number of stalled XFER cycles before abort; legal range at least 1.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 in_bus_valid  in  1 / in_bus_data  in  DATA_W / out_bus_ready  out  1  inbound bus handshake.
REQ-010 out_bus_valid  out  1 / out_bus_data  out  DATA_W / in_bus_ready  in  1  outbound bus handshake.
REQ-011 in_ack_bus_owned  in  1 / out_ack_bus_request  out  1 / out_ack_bus_id  out  2  completion ack bus.
REQ-012 out_fsm_valid  out  1 / out_fsm_data  out  DATA_W / in_fsm_ready  in  1  write path into the transaction FSM.
REQ-013 in_fsm_valid  in  1 / in_fsm_data  in  DATA_W / out_fsm_ready  out  1  read path out of the transaction FSM.
REQ-014 in_fsm_done  in  1  FSM signals last word processed.
REQ-015 out_fsm_start  out  1 (one-cycle pulse) / out_fsm_opcode  out  2 / out_fsm_enc_type  out  1 / out_address  out  8*ADDR_BYTES  transaction descriptor.
REQ-016 out_error  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 Command byte layout: [7]=enc_type, [6]=reserved, [5:4]=dest_id, [3:2]=src_id, [1:0]=opcode (RD_KEY=0, RD_TEXT=1, WR_RES=2, OTHER=3).
REQ-018 States: IDLE, ADDR, XFER, ACK.
REQ-019 IDLE: out_bus_ready=1; on an accepted beat, the port SHALL latch opcode and enc_type and go to ADDR if the opcode is RD_KEY or RD_TEXT with src_id==MOD_ID, or WR_RES with dest_id==MOD_ID; all other bytes, including OTHER, are consumed and ignored.
REQ-020 ADDR: out_bus_ready=1; each accepted beat writes byte k (k=0 first) into out_address[8k+7:8k], least-significant byte first; bits above bit 7 of in_bus_data are ignored.
REQ-021 After exactly ADDR_BYTES accepted beats, the port SHALL pulse out_fsm_start for one cycle and enter XFER.
REQ-022 XFER read direction (RD_*): in_fsm_* feeds the FIFO, with out_fsm_ready = !full; the FIFO drives out_bus_*, with out_bus_valid = !empty; out_bus_ready=0 throughout.
REQ-023 XFER write direction (WR_RES): in_bus_* feeds the FIFO, with out_bus_ready = !full; the FIFO drives out_fsm_*, with out_fsm_valid = !empty.
REQ-024 FIFO latency: a word pushed in cycle N is visible at the output in cycle N+1; simultaneous push and pop when full is allowed; pointers wrap modulo FIFO_DEPTH.
REQ-025 in_fsm_done is latched; XFER exits to ACK when done is latched and the FIFO is empty; in write direction, bus beats arriving after done are not accepted.
REQ-026 The stall counter resets on any push or pop; on reaching TIMEOUT_CYC, the port SHALL pulse out_error, flush the FIFO and go to IDLE without acking.
REQ-027 ACK: out_ack_bus_request=1 and out_ack_bus_id=MOD_ID; on the first cycle in_ack_bus_owned=1, the request drops the next cycle and the state goes to IDLE.
REQ-028 out_address, out_fsm_opcode and out_fsm_enc_type SHALL hold stable from out_fsm_start until the next command is decoded.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, FIFO empty, counters=0, done latch=0, and all outputs 0 except out_bus_ready.
REQ-030 Reset asserted mid-XFER or mid-ACK SHALL abort the transaction with no out_error and no ack request in the following cycle.

Structure
REQ-031 Shared package mem_port_pkg: unit IDs (MEM/SHA/AES), opcode constants, command-byte field positions, state encoding.
REQ-032 The FIFO is sub-module mem_port_fifo, parametrised by DATA_W and FIFO_DEPTH, and instantiated once with its direction muxed by opcode.

Verification (DATA_W=8, ADDR_BYTES=3, MOD_ID=0, FIFO_DEPTH=4)
REQ-033 Bytes 0x01,0x56,0x34,0x12 -> out_fsm_start pulses one cycle after 0x12, with out_address=0x123456 and opcode=RD_TEXT.
REQ-034 Command 0x82, address 3 beats, then bus words A0..A5 with in_fsm_ready held low 6 cycles -> out_bus_ready drops after 4 words; all 6 words reach out_fsm_data in order.
REQ-035 RD_KEY, then FSM supplies 3 words, done, and in_bus_ready=1 -> 3 bus beats; ACK with id 0; request drops the cycle after owned=1.
REQ-036 Command 0x13 (OTHER) and command 0x11 (dest mismatch for WR... src 0 read ok) vs 0x05 (src=1) -> 0x05 and 0x13 are ignored and the state remains IDLE.
REQ-037 XFER with no handshakes for 255 cycles -> out_error pulses once, FIFO empty, IDLE, no ack request.
REQ-038 rst asserted while the FIFO holds 3 words -> all outputs are at reset values in the next cycle, and a fresh command decodes normally.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory command channel port: unit IDs, opcodes,
// command-byte field positions and FSM state encoding.
package mem_port_pkg;

  localparam logic [1:0] UNIT_MEM = 2'd0;
  localparam logic [1:0] UNIT_SHA = 2'd1;
  localparam logic [1:0] UNIT_AES = 2'd2;

  localparam logic [1:0] OP_RD_KEY  = 2'd0;
  localparam logic [1:0] OP_RD_TEXT = 2'd1;
  localparam logic [1:0] OP_WR_RES  = 2'd2;
  localparam logic [1:0] OP_OTHER   = 2'd3;

  localparam int CMD_ENC_BIT  = 7;
  localparam int CMD_DEST_LSB = 4;
  localparam int CMD_SRC_LSB  = 2;
  localparam int CMD_OP_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_XFER = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // Takes only the low six command bits; reads are addressed by source ID,
  // result writes by destination ID.
  function automatic logic cmd_match(input logic [5:0] cmd, input logic [1:0] mod_id);
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dest;
    op   = cmd[CMD_OP_LSB +: 2];
    src  = cmd[CMD_SRC_LSB +: 2];
    dest = cmd[CMD_DEST_LSB +: 2];
    return (((op == OP_RD_KEY) || (op == OP_RD_TEXT)) && (src == mod_id)) ||
           ((op == OP_WR_RES) && (dest == mod_id));
  endfunction

endpackage

// File: rtl/mem_port_fifo.sv
// Small synchronous FIFO; a word written in one cycle is readable the next.
// Supports push and pop in the same cycle even when full.
module mem_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_channel_port.sv
// Command channel port: decodes a command byte plus address beats, then moves
// data between the bus and the transaction FSM through one shared FIFO.
module mem_cmd_channel_port
  import mem_port_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         ADDR_BYTES  = 3,
  parameter logic [1:0] MOD_ID      = 2'b00,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_bus_valid,
  input  logic [DATA_W-1:0]       in_bus_data,
  output logic                    out_bus_ready,
  output logic                    out_bus_valid,
  output logic [DATA_W-1:0]       out_bus_data,
  input  logic                    in_bus_ready,
  input  logic                    in_ack_bus_owned,
  output logic                    out_ack_bus_request,
  output logic [1:0]              out_ack_bus_id,
  output logic                    out_fsm_valid,
  output logic [DATA_W-1:0]       out_fsm_data,
  input  logic                    in_fsm_ready,
  input  logic                    in_fsm_valid,
  input  logic [DATA_W-1:0]       in_fsm_data,
  output logic                    out_fsm_ready,
  input  logic                    in_fsm_done,
  output logic                    out_fsm_start,
  output logic [1:0]              out_fsm_opcode,
  output logic                    out_fsm_enc_type,
  output logic [8*ADDR_BYTES-1:0] out_address,
  output logic                    out_error
);
  localparam int               STALL_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       LAST_BEAT  = 2'(ADDR_BYTES - 1);

  state_t                 state_reg, state_next;
  logic [1:0]             opcode_reg;
  logic                   enc_reg;
  logic [1:0]             addr_cnt_reg;
  logic [8*ADDR_BYTES-1:0] addr_reg;
  logic                   done_reg;
  logic [STALL_W-1:0]     stall_cnt_reg;
  logic                   start_reg;
  logic                   error_reg;

  logic                   fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0]      fifo_din, fifo_dout;
  logic                   rd_dir;
  logic                   cmd_hit;
  logic                   addr_we;

  assign rd_dir  = (opcode_reg == OP_RD_KEY) || (opcode_reg == OP_RD_TEXT);
  assign cmd_hit = cmd_match(in_bus_data[5:0], MOD_ID);
  assign addr_we = (state_reg == ST_ADDR) && in_bus_valid;

  if (DATA_W > 8) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^in_bus_data[DATA_W-1:8];
  end

  mem_port_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next          = state_reg;
    out_bus_ready       = 1'b0;
    out_bus_valid       = 1'b0;
    out_bus_data        = '0;
    out_fsm_valid       = 1'b0;
    out_fsm_data        = '0;
    out_fsm_ready       = 1'b0;
    out_ack_bus_request = 1'b0;
    out_ack_bus_id      = 2'b00;
    fifo_push           = 1'b0;
    fifo_pop            = 1'b0;
    fifo_flush          = 1'b0;
    fifo_din            = '0;
    case (state_reg)
      ST_IDLE: begin
        out_bus_ready = 1'b1;
        if (in_bus_valid && cmd_hit) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        out_bus_ready = 1'b1;
        if (in_bus_valid && (addr_cnt_reg == LAST_BEAT)) state_next = ST_XFER;
      end
      ST_XFER: begin
        if (rd_dir) begin
          out_fsm_ready = !fifo_full;
          fifo_push     = in_fsm_valid && !fifo_full;
          fifo_din      = in_fsm_data;
          out_bus_valid = !fifo_empty;
          out_bus_data  = fifo_dout;
          fifo_pop      = in_bus_ready && !fifo_empty;
        end else begin
          // Once done is seen, no further bus words are taken in.
          out_bus_ready = !fifo_full && !done_reg;
          fifo_push     = in_bus_valid && !fifo_full && !done_reg;
          fifo_din      = in_bus_data;
          out_fsm_valid = !fifo_empty;
          out_fsm_data  = fifo_dout;
          fifo_pop      = in_fsm_ready && !fifo_empty;
        end
        if (done_reg && fifo_empty) begin
          state_next = ST_ACK;
        end else if (!fifo_push && !fifo_pop && (stall_cnt_reg == STALL_LAST)) begin
          fifo_flush = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        out_ack_bus_request = 1'b1;
        out_ack_bus_id      = MOD_ID;
        if (in_ack_bus_owned) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Descriptor fields change only when a command addressed to this port decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_reg <= '0;
      enc_reg    <= 1'b0;
    end else if ((state_reg == ST_IDLE) && in_bus_valid && cmd_hit) begin
      opcode_reg <= in_bus_data[CMD_OP_LSB +: 2];
      enc_reg    <= in_bus_data[CMD_ENC_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_reg == ST_IDLE)) addr_cnt_reg <= '0;
    else if (addr_we)                  addr_cnt_reg <= addr_cnt_reg + 1'b1;
  end

  for (genvar gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr
    always_ff @(posedge clk) begin
      if (rst)                                      addr_reg[8*gi +: 8] <= '0;
      else if (addr_we && (addr_cnt_reg == 2'(gi))) addr_reg[8*gi +: 8] <= in_bus_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_reg     <= 1'b0;
      error_reg     <= 1'b0;
      done_reg      <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      start_reg <= addr_we && (addr_cnt_reg == LAST_BEAT);
      error_reg <= fifo_flush;
      if ((state_reg != ST_XFER) || (state_next != ST_XFER)) done_reg <= 1'b0;
      else if (in_fsm_done)                                  done_reg <= 1'b1;
      if ((state_reg != ST_XFER) || fifo_push || fifo_pop) stall_cnt_reg <= '0;
      else                                                 stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign out_fsm_start    = start_reg;
  assign out_error        = error_reg;
  assign out_fsm_opcode   = opcode_reg;
  assign out_fsm_enc_type = enc_reg;
  assign out_address      = addr_reg;

endmodule

// File: tb/tb_mem_cmd_channel_port.sv
// Scoreboard bench for mem_cmd_channel_port: stimulus queues expected words,
// descriptors and acks; a negedge monitor pops and compares them.
module tb_mem_cmd_channel_port;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_bus_valid, in_bus_ready, in_ack_bus_owned;
  logic [7:0]  in_bus_data, in_fsm_data;
  logic        in_fsm_ready, in_fsm_valid, in_fsm_done;
  logic        out_bus_ready, out_bus_valid, out_ack_bus_request;
  logic [7:0]  out_bus_data, out_fsm_data;
  logic [1:0]  out_ack_bus_id, out_fsm_opcode;
  logic        out_fsm_valid, out_fsm_ready, out_fsm_start, out_fsm_enc_type, out_error;
  logic [23:0] out_address;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_bus[$];
  logic [7:0]  exp_fsm[$];
  logic [26:0] exp_start[$];
  logic [1:0]  exp_ack[$];
  int          err_cycles = 0;
  int          req_cycles = 0;

  always #5 clk = ~clk;

  mem_cmd_channel_port #(
    .DATA_W(8), .ADDR_BYTES(3), .MOD_ID(2'b00), .FIFO_DEPTH(4), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .rst(rst),
    .in_bus_valid(in_bus_valid), .in_bus_data(in_bus_data), .out_bus_ready(out_bus_ready),
    .out_bus_valid(out_bus_valid), .out_bus_data(out_bus_data), .in_bus_ready(in_bus_ready),
    .in_ack_bus_owned(in_ack_bus_owned), .out_ack_bus_request(out_ack_bus_request),
    .out_ack_bus_id(out_ack_bus_id),
    .out_fsm_valid(out_fsm_valid), .out_fsm_data(out_fsm_data), .in_fsm_ready(in_fsm_ready),
    .in_fsm_valid(in_fsm_valid), .in_fsm_data(in_fsm_data), .out_fsm_ready(out_fsm_ready),
    .in_fsm_done(in_fsm_done), .out_fsm_start(out_fsm_start), .out_fsm_opcode(out_fsm_opcode),
    .out_fsm_enc_type(out_fsm_enc_type), .out_address(out_address), .out_error(out_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_bus_valid && in_bus_ready) begin
        if (exp_bus.size() == 0) check("bus_unexpected", 32'(out_bus_data), 32'hFFFF_FFFF);
        else check("bus_word", 32'(out_bus_data), 32'(exp_bus.pop_front()));
      end
      if (out_fsm_valid && in_fsm_ready) begin
        if (exp_fsm.size() == 0) check("fsm_unexpected", 32'(out_fsm_data), 32'hFFFF_FFFF);
        else check("fsm_word", 32'(out_fsm_data), 32'(exp_fsm.pop_front()));
      end
      if (out_fsm_start) begin
        if (exp_start.size() == 0)
          check("start_unexpected", 32'({out_fsm_enc_type, out_fsm_opcode, out_address}), 32'hFFFF_FFFF);
        else
          check("start_desc", 32'({out_fsm_enc_type, out_fsm_opcode, out_address}), 32'(exp_start.pop_front()));
      end
      if (out_ack_bus_request && in_ack_bus_owned) begin
        if (exp_ack.size() == 0) check("ack_unexpected", 32'(out_ack_bus_id), 32'hFFFF_FFFF);
        else check("ack_id", 32'(out_ack_bus_id), 32'(exp_ack.pop_front()));
      end
      if (out_error) err_cycles++;
      if (out_ack_bus_request) req_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_bus_valid = 1'b1;
    in_bus_data  = b;
    @(negedge clk);
    while (!out_bus_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("bus_accept_timeout", 32'(n), 32'd0);
    tick();
    in_bus_valid = 1'b0;
  endtask

  task automatic fsm_send(input logic [7:0] w);
    int n = 0;
    in_fsm_valid = 1'b1;
    in_fsm_data  = w;
    @(negedge clk);
    while (!out_fsm_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("fsm_accept_timeout", 32'(n), 32'd0);
    tick();
    in_fsm_valid = 1'b0;
  endtask

  task automatic pulse_done();
    in_fsm_done = 1'b1;
    tick();
    in_fsm_done = 1'b0;
  endtask

  task automatic finish_ack();
    int n = 0;
    exp_ack.push_back(2'b00);
    while (!out_ack_bus_request && n < 100) begin
      tick();
      n++;
    end
    check("ack_request_seen", 32'(out_ack_bus_request), 32'd1);
    in_ack_bus_owned = 1'b1;
    tick();
    in_ack_bus_owned = 1'b0;
    check("ack_request_drop", 32'(out_ack_bus_request), 32'd0);
    check("ack_back_idle", 32'(out_bus_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_ready"}, 32'(out_bus_ready), 32'd1);
    check({tag, "_zero_outs"},
          32'({out_bus_valid, out_fsm_valid, out_fsm_ready, out_fsm_start, out_error,
               out_ack_bus_request, out_ack_bus_id, out_fsm_opcode, out_fsm_enc_type}), 32'd0);
    check({tag, "_address"}, 32'(out_address), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_bus_valid = 0; in_bus_data = 0; in_bus_ready = 0; in_ack_bus_owned = 0;
    in_fsm_ready = 0; in_fsm_valid = 0; in_fsm_data = 0; in_fsm_done = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // RD_TEXT decode: start pulses the cycle after the last address byte.
    exp_start.push_back({1'b0, 2'd1, 24'h123456});
    send_byte(8'h01); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("start_pulse_on", 32'(out_fsm_start), 32'd1);
    tick();
    check("start_pulse_off", 32'(out_fsm_start), 32'd0);
    check("addr_hold", 32'(out_address), 32'h123456);
    pulse_done();
    finish_ack();

    // RD_KEY: three FSM words drained to the bus, then ack.
    in_bus_ready = 1'b1;
    exp_start.push_back({1'b0, 2'd0, 24'hCCBBAA});
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    foreach (exp_bus[i]) exp_bus.delete(i);
    exp_bus.push_back(8'h11); exp_bus.push_back(8'h22); exp_bus.push_back(8'h33);
    fsm_send(8'h11); fsm_send(8'h22); fsm_send(8'h33);
    pulse_done();
    finish_ack();
    in_bus_ready = 1'b0;
    check("rd_key_drained", 32'(exp_bus.size()), 32'd0);

    // WR_RES with enc_type: FIFO fills, bus backpressure, then drains in order.
    exp_start.push_back({1'b1, 2'd2, 24'h030201});
    send_byte(8'h82); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    for (int i = 0; i < 6; i++) exp_fsm.push_back(8'hA0 + 8'(i));
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    in_bus_valid = 1'b1;
    in_bus_data  = 8'hA4;
    @(negedge clk);
    check("wr_full_ready_low", 32'(out_bus_ready), 32'd0);
    tick(); tick();
    check("wr_full_ready_still_low", 32'(out_bus_ready), 32'd0);
    in_fsm_ready = 1'b1;
    send_byte(8'hA4); send_byte(8'hA5);
    pulse_done();
    finish_ack();
    in_fsm_ready = 1'b0;
    check("wr_all_words", 32'(exp_fsm.size()), 32'd0);

    // Ignored commands, then 0x11 decodes; its XFER stalls into a timeout.
    send_byte(8'h13); send_byte(8'h05);
    check("ignored_idle_ready", 32'(out_bus_ready), 32'd1);
    exp_start.push_back({1'b0, 2'd1, 24'hDEBC9A});
    send_byte(8'h11); send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
    check("to_start", 32'(out_fsm_start), 32'd1);
    err_cycles = 0;
    req_cycles = 0;
    k = 0;
    while (!out_error && k < 400) begin
      tick();
      k++;
    end
    check("timeout_latency", 32'(k), 32'd255);
    check("timeout_idle", 32'({out_bus_ready, out_bus_valid}), 32'b10);
    for (int i = 0; i < 5; i++) tick();
    check("timeout_single_pulse", 32'(err_cycles), 32'd1);
    check("timeout_no_ack", 32'(req_cycles), 32'd0);

    // Reset with three words buffered, then a fresh command.
    exp_start.push_back({1'b0, 2'd1, 24'h332211});
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    fsm_send(8'h51); fsm_send(8'h52); fsm_send(8'h53);
    check("pre_reset_valid", 32'(out_bus_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b0;
    in_bus_ready = 1'b1;
    tick();
    check("post_reset_empty", 32'(out_bus_valid), 32'd0);
    exp_start.push_back({1'b0, 2'd0, 24'h302010});
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    check("fresh_start", 32'(out_fsm_start), 32'd1);
    pulse_done();
    finish_ack();
    in_bus_ready = 1'b0;
    tick();

    check("start_queue_empty", 32'(exp_start.size()), 32'd0);
    check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
